sine_phase_sequencer: RTL
=========================

// Module: sine_phase_sequencer
// PURPOSE
//  Parametrised quarter-wave sine LUT sequencer built on a phase accumulator (DDS style).
//  Each cycle it outputs the LUT address, the mirror flag (descending quadrants) and the sign bit.
//  The tuning word (FTW) sets the output frequency and has a ready/valid update port.
//  A new FTW takes effect only at a period wrap, so frequency changes are glitch-free.
//  Sits between the sine ROM and the DAC/PWM output stage.
// PARAMETERS
//  ADDR_W   6                          LUT address bits (2^ADDR_W samples per quadrant)
//  ACC_W    16                         accumulator width; must be >= ADDR_W+2
//  DEF_FTW  1<<(ACC_W-ADDR_W-2)        FTW after reset; one LUT step per cycle
// PORTS
//  clk          in   1       clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  en           in   1       advance phase this cycle
//  ftw_valid    in   1       new tuning word offered
//  ftw          in   ACC_W   tuning word (phase increment per enabled cycle)
//  ftw_ready    out  1       pending slot empty; transfer when ftw_valid&&ftw_ready
//  addr         out  ADDR_W  LUT address (already mirrored)
//  phase_pos    out  1       1 in Q2/Q4 (descending address)
//  sign_bit     out  1       1 in Q3/Q4 (negate LUT output)
//  quadrant     out  2       Q1..Q4 = 0..3
//  addr_valid   out  1       1 on cycles following an enabled edge
//  wrap         out  1       1-cycle pulse: current sample is the first of a new period
// BEHAVIOUR
//  - Reset: acc=0, active FTW=DEF_FTW, pending slot empty, ftw_ready=1.
//    All outputs 0; rst mid-operation discards any pending FTW.
//  - Per enabled edge: acc <= acc+ftw_act (mod 2^ACC_W).
//    Outputs register the decode of acc's pre-increment value (latency 1).
//  - Decode: quadrant=ph[ACC_W-1:ACC_W-2]; idx=ph[ACC_W-3 -: ADDR_W].
//    addr = idx in Q1/Q3, ~idx in Q2/Q4; phase_pos=quadrant[0]; sign_bit=quadrant[1].
//  - Quadrant FSM Q1->Q2->Q3->Q4->Q1 is held in the quadrant register.
//    Quadrants are skipped only when FTW >= 2^(ACC_W-2), which is legal.
//  - wrap: set on the output sample whose phase follows an accumulator carry-out; else 0.
//  - en=0: acc, addr, quadrant and flags hold; addr_valid=0; wrap=0.
//  - FTW handshake, en=1 path: an accepted FTW goes to the pending slot and ftw_ready drops.
//    At the next carry-out the pending word becomes active for the following step.
//    The slot then clears and ftw_ready rises the next cycle.
//  - FTW handshake, en=0 path: an accepted FTW loads straight into the active FTW.
//  - FTW handshake, zero FTW: if the active FTW is 0, a pending word is applied on the next enabled edge.
//  - Accept on the same cycle as a carry-out: the word waits for the next wrap.
//  - ftw_valid while ftw_ready=0 is ignored; the master must hold it.
// CONFIGURATION
//  PHASE_OFFSET_EN defined:
//    adds input phase_off [ACC_W-1:0]; ph = acc + phase_off (mod 2^ACC_W) feeds the decode.
//    wrap and FTW timing are still derived from acc only.
//  PHASE_OFFSET_EN undefined: port absent and ph = acc.
// STRUCTURE
//  Shared package sine_pkg: quadrant encodings Q1..Q4 (2'b00..2'b11) and default ADDR_W/ACC_W.
//  Sub-module phase_accumulator: ACC_W register, en, increment input, carry-out output.
//  Top level: FTW active/pending registers, handshake, decode and output registers.
// TESTING (ADDR_W=6, ACC_W=16 unless noted)
//  1 Reset, en=1, default FTW=256.
//    -> addr 0..63 (Q1), 63..0 (Q2, phase_pos=1), 0..63 (Q3, sign=1), 63..0 (Q4).
//    -> then wrap=1 with addr=0; the period repeats every 256 enabled cycles.
//  2 Idle load ftw=512 with en=0, then run.
//    -> addr steps 0,2,4..62, then 63,61..1 (Q2); wrap every 128 cycles.
//  3 Running at 256, offer ftw=128 mid-Q2.
//    -> accepted, ftw_ready=0; a second offer is ignored.
//    -> steps stay 1 until wrap, then addr advances every 2 cycles and ftw_ready returns to 1.
//  4 en=0 for 5 cycles mid-Q3 at addr=20.
//    -> addr=20, sign_bit=1 held, addr_valid=0; resume gives 21 with no skipped sample.
//  5 rst=1 for one cycle mid-Q4 with a pending FTW.
//    -> next cycle addr=0, quadrant=0, flags 0, ftw_ready=1, active FTW=256.
//  6 PHASE_OFFSET_EN, phase_off=16'h4000, en=1.
//    -> first sample quadrant=1, addr=63, phase_pos=1, sign_bit=0; wrap still on the acc carry.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared definitions for the sine phase sequencer: quadrant encoding and
// default LUT/accumulator geometry.
package sine_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_ACC_W  = 16;

  typedef enum logic [1:0] {
    Q1 = 2'b00,
    Q2 = 2'b01,
    Q3 = 2'b10,
    Q4 = 2'b11
  } quad_t;

endpackage

// File: rtl/sine_phase_sequencer_phase_accumulator.sv
// Wrapping phase accumulator; carry flags the increment that crosses a full
// period so the sequencer can time wrap pulses and tuning-word swaps.
module phase_accumulator #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W:0]   sum_next;

  assign sum_next = {1'b0, acc_reg} + {1'b0, inc};
  assign acc      = acc_reg;
  assign carry    = en & sum_next[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum_next[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sine_phase_sequencer.sv
// Quarter-wave sine LUT sequencer (DDS). Optional phase offset input is
// enabled with the PHASE_OFFSET_EN macro.
module sine_phase_sequencer
  import sine_pkg::*;
#(
  parameter int               ADDR_W  = DEF_ADDR_W,
  parameter int               ACC_W   = DEF_ACC_W,
  parameter logic [ACC_W-1:0] DEF_FTW = {{(ACC_W-1){1'b0}}, 1'b1} << (ACC_W-ADDR_W-2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ftw_valid,
  input  logic [ACC_W-1:0]  ftw,
`ifdef PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]  phase_off,
`endif
  output logic              ftw_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              phase_pos,
  output logic              sign_bit,
  output logic [1:0]        quadrant,
  output logic              addr_valid,
  output logic              wrap
);

  logic [ACC_W-1:0]  ftw_act_reg;
  logic [ACC_W-1:0]  ftw_pend_reg;
  logic              pend_valid_reg;
  logic [ACC_W-1:0]  acc;
  logic              carry;
  logic [ACC_W-1:0]  ph;
  quad_t             quad_next;
  quad_t             quad_reg;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              addr_valid_reg;
  logic              wrap_reg;
  logic              after_carry_reg;
  logic              accept;

  phase_accumulator #(.ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .inc   (ftw_act_reg),
    .acc   (acc),
    .carry (carry)
  );

`ifdef PHASE_OFFSET_EN
  assign ph = acc + phase_off;
`else
  assign ph = acc;
`endif

  assign quad_next = quad_t'(ph[ACC_W-1 -: 2]);
  assign idx       = ADDR_W'(ph >> (ACC_W-ADDR_W-2));
  // Descending quadrants walk the quarter-wave table backwards.
  assign addr_next = quad_next[0] ? ~idx : idx;

  assign ftw_ready = ~pend_valid_reg;
  assign accept    = ftw_valid & ftw_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_act_reg     <= DEF_FTW;
      ftw_pend_reg    <= '0;
      pend_valid_reg  <= 1'b0;
      quad_reg        <= Q1;
      addr_reg        <= '0;
      addr_valid_reg  <= 1'b0;
      wrap_reg        <= 1'b0;
      after_carry_reg <= 1'b0;
    end else begin
      addr_valid_reg <= en;
      wrap_reg       <= en & after_carry_reg;
      if (en) begin
        quad_reg        <= quad_next;
        addr_reg        <= addr_next;
        after_carry_reg <= carry;
      end
      // While idle the frequency can change without glitching, so load directly.
      if (accept && !en) begin
        ftw_act_reg <= ftw;
      end else if (accept) begin
        ftw_pend_reg   <= ftw;
        pend_valid_reg <= 1'b1;
      end else if (pend_valid_reg && en && (carry || ftw_act_reg == '0)) begin
        ftw_act_reg    <= ftw_pend_reg;
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign addr       = addr_reg;
  assign quadrant   = quad_reg;
  assign phase_pos  = quad_reg[0];
  assign sign_bit   = quad_reg[1];
  assign addr_valid = addr_valid_reg;
  assign wrap       = wrap_reg;

endmodule
